uart_tx_fifo: RTL and testbench

Memory-mapped UART transmit peripheral. It is the transmitter counterpart to the CPU's UART receive path: it sends bytes from the CPU to the host.
- The MEM stage writes bytes into a small FIFO.
- A baud-rate serializer drains the FIFO onto the serial line as 8N1 frames.
- Status outputs (full, empty, count, busy, overflow) are read back through the MEM-stage peripheral read mux.

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmit peripheral: a small byte FIFO written by the MEM stage, drained by an
// 8N1 baud-rate serializer. All status outputs come straight from registers.
module uart_tx_fifo #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 10417,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             overflow,
    output logic             uart_tx,
    output logic [1:0]       state_dbg
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic               ovf_q, ovf_d;
    logic [7:0]         mem_q [DEPTH];

    logic wr_accept;
    logic pop;
    logic baud_done;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign uart_tx   = tx_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    assign wr_accept = wr_en & ~full;
    assign baud_done = (baud_q == BAUD_LAST);

    // FIFO occupancy and sticky overflow; a dropped write beats a same-cycle clear.
    always_comb begin
        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wr_en && full)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem_q[wptr_q] <= wr_data;
    end

    // State register process (FSM, counters, FIFO bookkeeping).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_accept)
                wptr_q <= wptr_q + PTR_W'(1);
            if (pop)
                rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // Next-state process; pops happen from IDLE or on the last STOP cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output process; the line is registered so it trails the state by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with BAUD_DIV=4, DEPTH=4: directed stimulus pushes expected bytes,
// a line monitor decodes frames and checks them against the expected queue.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       overflow;
    logic       uart_tx;
    logic [1:0] state_dbg;

    uart_tx_fifo #(.DEPTH(4), .BAUD_DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .overflow  (overflow),
        .uart_tx   (uart_tx),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_checks  = 0;
    int n_pass    = 0;
    int frames_rx = 0;
    int pushed    = 0;

    logic tr [0:127];
    int   busy_cnt;
    int   fall_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr1(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
    endtask

    task automatic idle_in();
        wr_en   = 1'b0;
        wr_data = 8'hFF;
    endtask

    task automatic observe(input int win);
        busy_cnt = 0;
        fall_idx = -1;
        for (int i = 0; i < win; i++) begin
            if (i > 0) @(negedge clk);
            tr[i] = uart_tx;
            busy_cnt += int'(busy);
            if (fall_idx < 0 && uart_tx == 1'b0) fall_idx = i;
        end
    endtask

    // pat holds bit times in order, leftmost first; each must last 4 cycles.
    task automatic check_bits(input logic [19:0] pat, input int nbits);
        logic b;
        int   f;
        if (fall_idx < 0) begin
            check("start_seen", 0, 1);
        end else begin
            f = fall_idx;
            for (int k = 0; k < nbits; k++) begin
                b = pat[nbits-1-k];
                check($sformatf("bit_time_%0d", k),
                      {tr[f+4*k], tr[f+4*k+1], tr[f+4*k+2], tr[f+4*k+3]}, {4{b}});
            end
        end
    endtask

    task automatic drain(input int limit);
        int done = 0;
        for (int i = 0; i < limit && done == 0; i++) begin
            @(negedge clk);
            if (empty && !busy) done = 1;
        end
        check("drain_done", done, 1);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [9:0] bits;
        logic       aborted;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                bits    = '0;
                aborted = 1'b0;
                for (int c = 1; c <= 38; c++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    if (c % 4 == 2) bits[c/4] = uart_tx;
                end
                if (!aborted) begin
                    frames_rx++;
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[9], 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame: got %02h required none", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", bits[8:1], e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int low_cnt;
        int bsy_cnt;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;

        @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single byte 0xA5 from idle.
        push(8'hA5);
        wr1(8'hA5);
        idle_in();
        check("t1_count", count, 1);
        check("t1_empty", empty, 0);
        check("t1_busy_pre", busy, 0);
        observe(60);
        check("t1_fall_lat", fall_idx, 2);
        check_bits(20'b0000000000_0101001011, 10);
        check("t1_busy_len", busy_cnt, 40);
        check("t1_empty_end", empty, 1);
        check("t1_idle_end", busy, 0);

        // Test 2: back-to-back frames 0x55, 0x0F.
        push(8'h55);
        push(8'h0F);
        wr1(8'h55);
        wr1(8'h0F);
        idle_in();
        check("t2_count", count, 1);
        observe(100);
        check("t2_fall_lat", fall_idx, 1);
        check_bits(20'b0101010101_0111100001, 20);
        check("t2_busy_len", busy_cnt, 80);
        check("t2_empty_end", empty, 1);

        // Test 3: six writes into a depth-4 FIFO; 0x06 is dropped.
        for (int i = 1; i <= 5; i++) push(8'(i));
        for (int i = 1; i <= 5; i++) wr1(8'(i));
        check("t3_full_pre", full, 1);
        check("t3_count_pre", count, 4);
        check("t3_ovf_pre", overflow, 0);
        wr1(8'h06);
        check("t3_ovf", overflow, 1);
        check("t3_full", full, 1);
        check("t3_count", count, 4);

        // Test 4: clear collides with a dropped write, then clear alone.
        wr_en   = 1'b1;
        wr_data = 8'h77;
        clr_ovf = 1'b1;
        @(negedge clk);
        idle_in();
        check("t4_set_wins", overflow, 1);
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t4_cleared", overflow, 0);
        drain(400);
        check("t3_frames", frames_rx, 8);
        check("t3_count_end", count, 0);

        // Test 5: reset during DATA bit 3 of a 0x00 frame with two bytes queued.
        wr1(8'h00);
        wr1(8'h11);
        wr1(8'h22);
        idle_in();
        check("t5_count_q", count, 2);
        repeat (16) @(negedge clk);
        check("t5_busy_pre", busy, 1);
        check("t5_line_low", uart_tx, 0);
        rst = 1'b1;
        #1;
        check("t5_tx_async", uart_tx, 1);
        check("t5_count", count, 0);
        check("t5_busy", busy, 0);
        check("t5_empty", empty, 1);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        low_cnt = 0;
        bsy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) low_cnt++;
            if (busy) bsy_cnt++;
        end
        check("t5_no_tx", low_cnt, 0);
        check("t5_no_busy", bsy_cnt, 0);

        // Test 6: write with simultaneous pop at count=2, then pointer wrap over 9 writes.
        push(8'h3C); push(8'hC3); push(8'h81); push(8'h7E); push(8'h18); push(8'hE7);
        wr1(8'h3C);
        wr1(8'hC3);
        wr1(8'h81);
        idle_in();
        repeat (38) @(negedge clk);
        check("t6_count_before", count, 2);
        wr1(8'h7E);
        check("t6_count_same", count, 2);
        wr1(8'h18);
        wr1(8'hE7);
        idle_in();
        check("t6_count_4", count, 4);
        check("t6_full", full, 1);
        drain(400);
        push(8'h42); push(8'h24); push(8'h99);
        wr1(8'h42);
        wr1(8'h24);
        wr1(8'h99);
        idle_in();
        drain(300);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_frames", frames_rx, pushed);
        check("final_ovf", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
